// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width helper and Gray/binary conversions shared by both FIFO pointer blocks
package fifo_pkg;
  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction
  // Operands are zero-extended, so any width up to 32 converts correctly
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational N-bit Gray-to-binary via prefix XOR
module gray2bin_conv #(
  parameter int N = 5
) (
  input  logic [N-1:0] g,
  output logic [N-1:0] b
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign b[i] = ^g[N-1:i];
  end
endmodule

// File: rtl/rptr_empty.sv
// rptr_empty: read pointer, empty/almost-empty, level and sticky underflow for the async FIFO.
// Define RPTR_LEVEL_EN to build the level and almost-empty logic; otherwise almost-empty mirrors empty.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ASIZE     = 4,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [ASIZE:0]   w2r_ptr,
  input  logic             rd_inc,
  output logic [ASIZE-1:0] rd_addr,
  output logic [ASIZE:0]   rd_ptr,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [ASIZE:0]   rd_level,
  output logic             rd_underflow
);
  localparam int PW = ptr_w(ASIZE);
  if (DSIZE < 1 || AE_THRESH < 0 || AE_THRESH > (1 << ASIZE)) begin : g_bad_param
    $error("rptr_empty: illegal DSIZE or AE_THRESH");
  end
  logic [PW-1:0] rbin, rbnext, rgnext;
  logic          rd_acc;
  assign rd_acc  = rd_inc & ~rd_empty;
  assign rbnext  = rbin + PW'(rd_acc);
  assign rgnext  = PW'(bin2gray(32'(rbnext)));
  assign rd_addr = rbin[ASIZE-1:0];
  // Compare against the next pointer so a last-entry read lands empty in the same cycle
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      rbin         <= '0;
      rd_ptr       <= '0;
      rd_empty     <= 1'b1;
      rd_underflow <= 1'b0;
    end else begin
      rbin         <= rbnext;
      rd_ptr       <= rgnext;
      rd_empty     <= (rgnext == w2r_ptr);
      rd_underflow <= rd_underflow | (rd_inc & rd_empty);
    end
`ifdef RPTR_LEVEL_EN
  logic [PW-1:0] wbin_s, diff;
  gray2bin_conv #(.N(PW)) u_conv (.g(w2r_ptr), .b(wbin_s));
  assign diff = wbin_s - rbnext;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      rd_level        <= '0;
      rd_almost_empty <= 1'b1;
    end else begin
      rd_level        <= diff;
      rd_almost_empty <= (32'(diff) <= AE_THRESH);
    end
`else
  assign rd_level        = '0;
  assign rd_almost_empty = rd_empty;
`endif
endmodule
